// File: rtl/sound_square_gen.sv
// Square-wave tone source: frequency timer, 8-step duty sequencer,
// length counter and volume envelope. Produces the enable / modulate /
// target_vol triple for the channel mixer. All timing comes from the
// frame-sequencer strobes (ce_freq, ce_len, ce_env).
module sound_square_gen #(
  parameter int LEN_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_freq,
  input  logic                ce_len,
  input  logic                ce_env,
  input  logic                trigger,
  input  logic [1:0]          duty,
  input  logic                length_load,
  input  logic [LEN_BITS-1:0] length_data,
  input  logic                length_enable,
  input  logic [10:0]         freq,
  input  logic [3:0]          env_init,
  input  logic                env_dir,
  input  logic [2:0]          env_period,
  output logic                enable,
  output logic                modulate,
  output logic [3:0]          target_vol
);

  // Length counter holds 0..2**LEN_BITS, so it needs one extra bit.
  localparam logic [LEN_BITS:0] LEN_FULL = {1'b1, {LEN_BITS{1'b0}}};

  // Duty waveforms, one byte per duty setting; bit n of a byte is the
  // output level at sequencer step n.
  //   duty 0: 00000001  duty 1: 10000001  duty 2: 10000111  duty 3: 01111110
  // (written step 0 first, so each byte below is the bit-reversed string)
  localparam logic [31:0] DUTY_ROWS = {8'b01111110,   // duty 3
                                       8'b11100001,   // duty 2
                                       8'b10000001,   // duty 1
                                       8'b10000000};  // duty 0

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [11:0]       freq_timer_reg, freq_timer_next;
  logic [2:0]        duty_step_reg,  duty_step_next;
  logic [LEN_BITS:0] len_cnt_reg,    len_cnt_next;
  logic [2:0]        env_timer_reg,  env_timer_next;
  logic [3:0]        vol_reg,        vol_next;
  logic              enable_reg,     enable_next;
  logic              modulate_reg,   modulate_next;

  // ---------------------------------------------------------------------
  // Derived values
  // ---------------------------------------------------------------------
  logic              dac_on;
  logic [11:0]       freq_reload;
  logic [LEN_BITS:0] len_load_value;
  logic [LEN_BITS:0] len_loaded;
  logic              len_expire;
  logic [3:0]        duty_bit_at_step;

  // The DAC is powered whenever the envelope could produce a non-zero level.
  assign dac_on         = (env_init != 4'd0) | env_dir;
  assign freq_reload    = 12'd2048 - {1'b0, freq};
  // length_data = 0 yields the full count (2**LEN_BITS).
  assign len_load_value = LEN_FULL - {1'b0, length_data};
  // A length write in the same cycle as a trigger is seen by the trigger.
  assign len_loaded     = length_load ? len_load_value : len_cnt_reg;

  // Current-step bit for each of the four duty waveforms; the live duty
  // input then picks one, so a duty change applies at the current step.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_duty_row
      localparam logic [7:0] ROW = DUTY_ROWS[gi*8 +: 8];
      assign duty_bit_at_step[gi] = ROW[duty_step_reg];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frequency timer and duty sequencer next state
  // ---------------------------------------------------------------------
  // Timer counts ce_freq strobes; on reaching 1 it reloads and steps the
  // sequencer. A timer of 0 (only seen before the first trigger) is treated
  // like 1 so the counter never wraps through its full range.
  always_comb begin
    freq_timer_next = freq_timer_reg;
    duty_step_next  = duty_step_reg;
    if (trigger) begin
      freq_timer_next = freq_reload;
    end else if (ce_freq) begin
      if (freq_timer_reg <= 12'd1) begin
        freq_timer_next = freq_reload;
        duty_step_next  = duty_step_reg + 3'd1;
      end else begin
        freq_timer_next = freq_timer_reg - 12'd1;
      end
    end
  end

  // Registered duty output follows the step register with one clk of lag.
  always_comb begin
    modulate_next = duty_bit_at_step[duty];
  end

  // ---------------------------------------------------------------------
  // Length counter next state
  // ---------------------------------------------------------------------
  // Trigger reloads an exhausted counter to full and suppresses ce_len for
  // that cycle. Otherwise a length write wins over a length tick.
  always_comb begin
    len_cnt_next = len_cnt_reg;
    len_expire   = 1'b0;
    if (trigger) begin
      len_cnt_next = (len_loaded == '0) ? LEN_FULL : len_loaded;
    end else if (length_load) begin
      len_cnt_next = len_load_value;
    end else if (ce_len && length_enable && (len_cnt_reg != '0)) begin
      len_cnt_next = len_cnt_reg - 1'b1;
      len_expire   = (len_cnt_reg == {{LEN_BITS{1'b0}}, 1'b1});
    end
  end

  // ---------------------------------------------------------------------
  // Volume envelope next state
  // ---------------------------------------------------------------------
  // env_period = 0 freezes the envelope. Volume saturates at 0 and 15.
  always_comb begin
    env_timer_next = env_timer_reg;
    vol_next       = vol_reg;
    if (trigger) begin
      env_timer_next = env_period;
      vol_next       = env_init;
    end else if (ce_env && (env_period != 3'd0)) begin
      if (env_timer_reg <= 3'd1) begin
        env_timer_next = env_period;
        if (env_dir && (vol_reg != 4'd15)) begin
          vol_next = vol_reg + 4'd1;
        end else if (!env_dir && (vol_reg != 4'd0)) begin
          vol_next = vol_reg - 4'd1;
        end
      end else begin
        env_timer_next = env_timer_reg - 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Channel enable next state
  // ---------------------------------------------------------------------
  // DAC off dominates; trigger turns the channel on; length expiry turns
  // it off on the same edge the counter reaches 0.
  always_comb begin
    enable_next = enable_reg;
    if (!dac_on) begin
      enable_next = 1'b0;
    end else if (trigger) begin
      enable_next = 1'b1;
    end else if (len_expire) begin
      enable_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------------
  // All state clears asynchronously; counters keep running while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_timer_reg <= '0;
      duty_step_reg  <= '0;
      len_cnt_reg    <= '0;
      env_timer_reg  <= '0;
      vol_reg        <= '0;
      enable_reg     <= 1'b0;
      modulate_reg   <= 1'b0;
    end else begin
      freq_timer_reg <= freq_timer_next;
      duty_step_reg  <= duty_step_next;
      len_cnt_reg    <= len_cnt_next;
      env_timer_reg  <= env_timer_next;
      vol_reg        <= vol_next;
      enable_reg     <= enable_next;
      modulate_reg   <= modulate_next;
    end
  end

  assign enable     = enable_reg;
  assign modulate   = modulate_reg;
  assign target_vol = vol_reg;

endmodule
